// File: rtl/udp_pkg.sv
// -----------------------------------------------------------------------------
// udp_pkg
// Shared definitions for the camera-to-UDP transmit path.
//   - sched_state_t : packet scheduler FSM states
//   - UDP_HDR       : UDP header bytes added to the payload for the UDP length
//   - IP_UDP_HDR    : IP + UDP header bytes added to the payload for the IP length
//   - FIFO_CNT_W    : width of the camera FIFO read-side data count
//   - RD_CNT_W      : width of the per-packet FIFO read counter
// -----------------------------------------------------------------------------
package udp_pkg;

    localparam int UDP_HDR    = 8;
    localparam int IP_UDP_HDR = 28;
    localparam int FIFO_CNT_W = 11;
    localparam int RD_CNT_W   = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_DATA,
        ST_START,
        ST_WAIT_ACK,
        ST_SEND,
        ST_GAP
    } sched_state_t;

endpackage

// File: rtl/edge_det.sv
// -----------------------------------------------------------------------------
// edge_det
// Registered rise/fall detector for a single-bit level that is already
// synchronous to clk. Both pulses are one cycle wide and appear one cycle
// after the edge of the input.
//   clk   in  : clock
//   reset in  : synchronous, active-high
//   sig   in  : level to watch
//   rise  out : one-cycle pulse after sig goes 0 -> 1
//   fall  out : one-cycle pulse after sig goes 1 -> 0
// -----------------------------------------------------------------------------
module edge_det (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic sig_q;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of order.
    always_ff @(posedge clk) begin
        if (reset) begin
            sig_q <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sig_q <= sig;
            rise  <= sig & ~sig_q;
            fall  <= ~sig & sig_q;
        end
    end

endmodule

// File: rtl/udp_tx_scheduler.sv
// -----------------------------------------------------------------------------
// udp_tx_scheduler
// Starts one fixed-size UDP packet each time a full payload sits in the camera
// FIFO, keeps a minimum idle gap between packets, numbers packets within each
// camera frame and flags timeout / length / overflow faults (sticky).
//   e_rxc           in  : 125 MHz clock (only clock)
//   reset           in  : synchronous, active-high
//   enable          in  : camera configured; gates new packets only
//   frame_start     in  : one-cycle VSYNC pulse
//   fifo_data_count in  : FIFO read-side used words
//   fifo_rd_en      in  : FIFO read strobe from the transmitter (monitored)
//   fifo_full       in  : FIFO write-side full
//   tx_busy         in  : transmitter is sending a packet
//   tx_start        out : one-cycle send request
//   tx_data_length  out : UDP length, PAYLOAD_BYTES + 8
//   tx_total_length out : IP total length, PAYLOAD_BYTES + 28
//   pkt_seq         out : packet index within the current frame
//   frame_cnt       out : frame number
//   err_timeout     out : transmitter never acknowledged a tx_start
//   err_len         out : a packet drained other than one payload
//   err_ovf         out : FIFO reported full while enabled
// -----------------------------------------------------------------------------
module udp_tx_scheduler
    import udp_pkg::*;
#(
    parameter int PAYLOAD_BYTES = 1024,
    parameter int IFG_CYCLES    = 64,
    parameter int ACK_TIMEOUT   = 4096
) (
    input  logic                  e_rxc,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  frame_start,
    input  logic [FIFO_CNT_W-1:0] fifo_data_count,
    input  logic                  fifo_rd_en,
    input  logic                  fifo_full,
    input  logic                  tx_busy,
    output logic                  tx_start,
    output logic [15:0]           tx_data_length,
    output logic [15:0]           tx_total_length,
    output logic [15:0]           pkt_seq,
    output logic [15:0]           frame_cnt,
    output logic                  err_timeout,
    output logic                  err_len,
    output logic                  err_ovf
);

    localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
    localparam int GAP_W = $clog2(IFG_CYCLES + 1);

    localparam logic [FIFO_CNT_W-1:0] PAYLOAD_WORDS = FIFO_CNT_W'(PAYLOAD_BYTES);
    localparam logic [RD_CNT_W-1:0]   PAYLOAD_RD    = RD_CNT_W'(PAYLOAD_BYTES);
    localparam logic [ACK_W-1:0]      ACK_LAST      = ACK_W'(ACK_TIMEOUT - 1);
    localparam logic [GAP_W-1:0]      GAP_LAST      = GAP_W'(IFG_CYCLES - 1);

    sched_state_t          state, state_nxt;
    logic [ACK_W-1:0]      ack_cnt;
    logic [GAP_W-1:0]      gap_cnt;
    logic [RD_CNT_W-1:0]   rd_cnt, rd_cnt_nxt;
    logic                  frame_pend;
    logic                  busy_rise, busy_fall;
    logic                  ack_timeout;
    logic                  pkt_end;
    logic                  enter_gap;

    // Header lengths never change, so they are valid even while in reset.
    assign tx_data_length  = 16'(PAYLOAD_BYTES + UDP_HDR);
    assign tx_total_length = 16'(PAYLOAD_BYTES + IP_UDP_HDR);

    edge_det u_busy_edge (
        .clk   (e_rxc),
        .reset (reset),
        .sig   (tx_busy),
        .rise  (busy_rise),
        .fall  (busy_fall)
    );

    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        ack_timeout = 1'b0;
        pkt_end     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) state_nxt = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                if (!enable)                             state_nxt = ST_IDLE;
                else if (fifo_data_count >= PAYLOAD_WORDS) state_nxt = ST_START;
            end
            ST_START: begin
                state_nxt = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (busy_rise) begin
                    state_nxt = ST_SEND;
                end else if (ack_cnt == ACK_LAST) begin
                    ack_timeout = 1'b1;
                    state_nxt   = ST_GAP;
                end
            end
            ST_SEND: begin
                if (busy_fall) begin
                    pkt_end   = 1'b1;
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) state_nxt = enable ? ST_WAIT_DATA : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign enter_gap = ack_timeout | pkt_end;

    // Read counter for the packet in flight; a read on the closing cycle still
    // counts toward the length check.
    always_comb begin
        rd_cnt_nxt = rd_cnt;
        if (state == ST_START) begin
            rd_cnt_nxt = '0;
        end else if (state == ST_SEND && fifo_rd_en && rd_cnt != '1) begin
            rd_cnt_nxt = rd_cnt + RD_CNT_W'(1);
        end
    end

    always_ff @(posedge e_rxc) begin
        if (reset) begin
            state       <= ST_IDLE;
            tx_start    <= 1'b0;
            pkt_seq     <= '0;
            frame_cnt   <= '0;
            frame_pend  <= 1'b0;
            ack_cnt     <= '0;
            gap_cnt     <= '0;
            rd_cnt      <= '0;
            err_timeout <= 1'b0;
            err_len     <= 1'b0;
            err_ovf     <= 1'b0;
        end else begin
            state    <= state_nxt;
            tx_start <= (state_nxt == ST_START);
            ack_cnt  <= (state == ST_WAIT_ACK) ? ack_cnt + ACK_W'(1) : '0;
            gap_cnt  <= (state == ST_GAP) ? gap_cnt + GAP_W'(1) : '0;
            rd_cnt   <= rd_cnt_nxt;

            // A frame boundary seen while a packet is in flight is held until
            // that packet closes, so pkt_seq stays stable for the transmitter.
            if (enter_gap) begin
                if (frame_start || frame_pend) begin
                    pkt_seq    <= '0;
                    frame_cnt  <= frame_cnt + 16'd1;
                    frame_pend <= 1'b0;
                end else if (pkt_end) begin
                    pkt_seq <= pkt_seq + 16'd1;
                end
            end else if (frame_start) begin
                if (state inside {ST_START, ST_WAIT_ACK, ST_SEND}) begin
                    frame_pend <= 1'b1;
                end else begin
                    pkt_seq   <= '0;
                    frame_cnt <= frame_cnt + 16'd1;
                end
            end

            if (ack_timeout)                         err_timeout <= 1'b1;
            if (pkt_end && rd_cnt_nxt != PAYLOAD_RD) err_len     <= 1'b1;
            if (fifo_full && enable)                 err_ovf     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_udp_tx_scheduler
// Scoreboard bench: the stimulus side pushes the packet number and frame number
// each tx_start should carry (from a simple packet/frame counting model); a
// monitor pops and compares on every tx_start. Directed checks cover reset,
// latency, gap, timeout, error flags, enable drop and mid-packet reset.
// -----------------------------------------------------------------------------
module tb_udp_tx_scheduler;

    localparam int PAYLOAD = 1024;
    localparam int IFG     = 64;
    localparam int ACK_TO  = 4096;

    logic        e_rxc = 1'b0;
    logic        reset, enable, frame_start, fifo_rd_en, fifo_full, tx_busy;
    logic [10:0] fifo_data_count;
    logic        tx_start;
    logic [15:0] tx_data_length, tx_total_length, pkt_seq, frame_cnt;
    logic        err_timeout, err_len, err_ovf;

    typedef struct {
        logic [15:0] seq;
        logic [15:0] frame;
    } exp_t;

    exp_t        exp_q[$];
    int          total       = 0;
    int          bad         = 0;
    int          starts_seen = 0;
    logic        prev_start  = 1'b0;
    logic [15:0] m_seq       = '0;
    logic [15:0] m_frame     = '0;

    udp_tx_scheduler #(
        .PAYLOAD_BYTES (PAYLOAD),
        .IFG_CYCLES    (IFG),
        .ACK_TIMEOUT   (ACK_TO)
    ) dut (
        .e_rxc           (e_rxc),
        .reset           (reset),
        .enable          (enable),
        .frame_start     (frame_start),
        .fifo_data_count (fifo_data_count),
        .fifo_rd_en      (fifo_rd_en),
        .fifo_full       (fifo_full),
        .tx_busy         (tx_busy),
        .tx_start        (tx_start),
        .tx_data_length  (tx_data_length),
        .tx_total_length (tx_total_length),
        .pkt_seq         (pkt_seq),
        .frame_cnt       (frame_cnt),
        .err_timeout     (err_timeout),
        .err_len         (err_len),
        .err_ovf         (err_ovf)
    );

    always #4 e_rxc = ~e_rxc;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_range(input string name, input int actual, input int lo, input int hi);
        total++;
        if (actual < lo || actual > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    // Monitor: every tx_start must be expected and carry the model's numbers.
    always @(negedge e_rxc) begin
        exp_t e;
        if (tx_start) begin
            starts_seen++;
            check("start_pulse_width", prev_start, 1'b0);
            check("start_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("start_pkt_seq", pkt_seq, e.seq);
                check("start_frame_cnt", frame_cnt, e.frame);
            end
        end
        prev_start <= tx_start;
    end

    initial begin
        repeat (60000) @(posedge e_rxc);
        $display("FAIL watchdog: cycle budget exhausted, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge e_rxc);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; frame_start = 1'b0; fifo_rd_en = 1'b0;
        fifo_full = 1'b0; tx_busy = 1'b0; fifo_data_count = '0;
        tick(2);
        check("rst_tx_start", tx_start, 0);
        check("rst_pkt_seq", pkt_seq, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_err_timeout", err_timeout, 0);
        check("rst_err_len", err_len, 0);
        check("rst_err_ovf", err_ovf, 0);
        check("rst_data_length", tx_data_length, PAYLOAD + 8);
        check("rst_total_length", tx_total_length, PAYLOAD + 28);
        reset = 1'b0;
        m_seq = '0;
        m_frame = '0;
    endtask

    // Queue the expected numbering, then wait (bounded) for the next tx_start.
    task automatic expect_start(input int bound, output int lat);
        exp_t e;
        e.seq = m_seq;
        e.frame = m_frame;
        exp_q.push_back(e);
        lat = 0;
        for (int i = 1; i <= bound; i++) begin
            tick();
            if (tx_start) begin
                lat = i;
                break;
            end
        end
        check("start_within_bound", lat != 0, 1'b1);
    endtask

    // Transmitter model, entered on the tx_start cycle. Returns on the cycle
    // tx_busy is dropped, with the model already advanced for that packet.
    task automatic serve(input int n_rd, input int n_fs, input bit drop_en);
        tick(3);
        tx_busy = 1'b1;
        tick(3);
        for (int i = 0; i < n_rd; i++) begin
            fifo_rd_en  = 1'b1;
            frame_start = (n_fs >= 1 && i == 100) || (n_fs >= 2 && i == 300);
            if (drop_en && i == 50) enable = 1'b0;
            tick();
        end
        fifo_rd_en  = 1'b0;
        frame_start = 1'b0;
        if (n_fs > 0) begin
            check("pending_frame_cnt_held", frame_cnt, m_frame);
            check("pending_pkt_seq_held", pkt_seq, m_seq);
        end
        tick(2);
        tx_busy = 1'b0;
        if (n_fs > 0) begin
            m_seq = '0;
            m_frame = m_frame + 16'd1;
        end else begin
            m_seq = m_seq + 16'd1;
        end
    endtask

    initial begin
        int lat;
        int s0;

        // Single packet, latency and inter-packet gap
        do_reset();
        fifo_full = 1'b1; tick(); fifo_full = 1'b0; tick();
        check("ovf_ignored_when_disabled", err_ovf, 0);
        enable = 1'b1; fifo_data_count = 11'd1023;
        tick(20);
        check("no_start_below_payload", starts_seen, 0);
        fifo_data_count = 11'd1024;
        expect_start(50, lat);
        check("start_latency", lat, 1);
        serve(PAYLOAD, 0, 0);
        expect_start(200, lat);
        check_range("ifg_gap_after_busy_fall", lat, IFG + 2, IFG + 4);
        fifo_data_count = '0;
        serve(PAYLOAD, 0, 0);
        tick(3);
        check("single_pkt_seq", pkt_seq, m_seq);
        check("single_err_timeout", err_timeout, 0);
        check("single_err_len", err_len, 0);
        check("single_err_ovf", err_ovf, 0);
        check("single_start_count", starts_seen, 2);

        // Back-to-back packets, then frame_start during GAP
        do_reset();
        fifo_data_count = 11'd2000;
        enable = 1'b1;
        for (int p = 0; p < 5; p++) begin
            expect_start(200, lat);
            serve(PAYLOAD, 0, 0);
        end
        tick(5);
        check("b2b_pkt_seq_before_frame", pkt_seq, m_seq);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        m_seq = '0;
        m_frame = m_frame + 16'd1;
        check("gap_frame_pkt_seq", pkt_seq, m_seq);
        check("gap_frame_cnt", frame_cnt, m_frame);
        expect_start(200, lat);
        serve(PAYLOAD, 0, 0);
        fifo_data_count = '0;
        tick(3);
        check("b2b_after_frame_pkt_seq", pkt_seq, m_seq);

        // Two frame_start pulses during SEND merge into one update
        do_reset();
        enable = 1'b1; fifo_data_count = 11'd1024;
        expect_start(50, lat);
        serve(PAYLOAD, 0, 0);
        expect_start(200, lat);
        fifo_data_count = '0;
        serve(PAYLOAD, 2, 0);
        tick(3);
        check("send_frame_pkt_seq", pkt_seq, m_seq);
        check("send_frame_cnt", frame_cnt, m_frame);

        // Acknowledge timeout and retry
        do_reset();
        enable = 1'b1; fifo_data_count = 11'd1024;
        expect_start(50, lat);
        serve(PAYLOAD, 0, 0);
        expect_start(200, lat);
        tick(ACK_TO - 6);
        check("timeout_not_early", err_timeout, 0);
        tick(8);
        check("timeout_flag", err_timeout, 1);
        check("timeout_pkt_seq_unchanged", pkt_seq, m_seq);
        check("timeout_no_len_err", err_len, 0);
        expect_start(200, lat);
        fifo_data_count = '0;
        serve(PAYLOAD, 0, 0);
        tick(3);
        check("retry_pkt_seq", pkt_seq, m_seq);
        check("timeout_sticky", err_timeout, 1);

        // Short packet and FIFO overflow
        do_reset();
        enable = 1'b1; fifo_data_count = 11'd1024;
        expect_start(50, lat);
        fifo_data_count = '0;
        serve(1000, 0, 0);
        tick(3);
        check("len_err_flag", err_len, 1);
        check("len_err_pkt_seq", pkt_seq, m_seq);
        check("ovf_before_full", err_ovf, 0);
        fifo_full = 1'b1; tick(); fifo_full = 1'b0; tick();
        check("ovf_flag", err_ovf, 1);
        tick(100);
        check("len_err_sticky", err_len, 1);
        check("ovf_sticky", err_ovf, 1);

        // Frame in IDLE, enable drop mid-packet, mid-packet reset
        do_reset();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        m_frame = m_frame + 16'd1;
        check("idle_frame_cnt", frame_cnt, m_frame);
        enable = 1'b1; fifo_data_count = 11'd1024;
        expect_start(50, lat);
        serve(PAYLOAD, 0, 1);
        s0 = starts_seen;
        tick(200);
        check("no_start_after_enable_drop", starts_seen, s0);
        check("enable_drop_pkt_completed", pkt_seq, m_seq);
        enable = 1'b1;
        expect_start(20, lat);
        check("restart_from_idle_latency", lat, 2);
        fifo_full = 1'b1; tick(); fifo_full = 1'b0;
        tick(2);
        tx_busy = 1'b1;
        tick(4);
        fifo_rd_en = 1'b1;
        tick(10);
        check("pre_reset_err_ovf", err_ovf, 1);
        check("pre_reset_frame_cnt", frame_cnt, m_frame);
        reset = 1'b1;
        tick();
        check("midpkt_rst_tx_start", tx_start, 0);
        check("midpkt_rst_pkt_seq", pkt_seq, 0);
        check("midpkt_rst_frame_cnt", frame_cnt, 0);
        check("midpkt_rst_err_timeout", err_timeout, 0);
        check("midpkt_rst_err_len", err_len, 0);
        check("midpkt_rst_err_ovf", err_ovf, 0);
        check("midpkt_rst_data_length", tx_data_length, PAYLOAD + 8);
        check("midpkt_rst_total_length", tx_total_length, PAYLOAD + 28);
        reset = 1'b0; tx_busy = 1'b0; fifo_rd_en = 1'b0; enable = 1'b0;
        fifo_data_count = '0;
        s0 = starts_seen;
        tick(20);
        check("no_start_after_reset", starts_seen, s0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
